// File: rtl/digit_entry_reg_if.sv
// Command/status bundle for the multi-digit entry register.
interface digit_entry_reg_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned DW = WIDTH * DEPTH;

   logic          clr;
   logic          ld;
   logic [DW-1:0] din;
   logic          push;
   logic          del;
   logic [WIDTH-1:0] digit;
   logic [DW-1:0] dout;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          ovf;
   logic          unf;

   modport master (
      output clr, ld, din, push, del, digit,
      input  dout, count, full, empty, ovf, unf
   );

   modport slave (
      input  clr, ld, din, push, del, digit,
      output dout, count, full, empty, ovf, unf
   );
endinterface

// File: rtl/digit_entry_reg.sv
// Multi-digit entry register: serial push/backspace/overwrite, parallel load,
// clear, valid-digit counter and one-cycle overflow/underflow pulses.
module digit_entry_reg #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   digit_entry_reg_if.slave bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned DW = WIDTH * DEPTH;

   logic [DW-1:0] dout_q, dout_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          full_c, empty_c;

   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == CW'(0));

   // State register; reset is asynchronous so outputs clear without an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         dout_q  <= dout_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Command decode: clr > ld > push/del; overwrite on an empty register degrades to push.
   always_comb begin
      dout_d  = dout_q;
      count_d = count_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (bus.clr) begin
         dout_d  = '0;
         count_d = '0;
      end else if (bus.ld) begin
         dout_d  = bus.din;
         count_d = CW'(DEPTH);
      end else if (bus.push && (!bus.del || empty_c)) begin
         dout_d = {dout_q[DW-WIDTH-1:0], bus.digit};
         if (full_c) ovf_d = 1'b1;
         else        count_d = CW'(count_q + CW'(1));
      end else if (bus.push && bus.del) begin
         dout_d[WIDTH-1:0] = bus.digit;
      end else if (bus.del) begin
         if (empty_c) begin
            unf_d = 1'b1;
         end else begin
            dout_d  = DW'(dout_q >> WIDTH);
            count_d = CW'(count_q - CW'(1));
         end
      end
   end

   assign bus.dout  = dout_q;
   assign bus.count = count_q;
   assign bus.full  = full_c;
   assign bus.empty = empty_c;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
endmodule

// File: tb/tb_digit_entry_reg.sv
// Directed bench for digit_entry_reg: 4x4 instance for the functional scenarios,
// 8x6 instance for the parameter sweep.
module tb_digit_entry_reg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   digit_entry_reg_if #(.WIDTH(4), .DEPTH(4)) u4 ();
   digit_entry_reg_if #(.WIDTH(8), .DEPTH(6)) u8 ();

   digit_entry_reg #(.WIDTH(4), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .bus(u4));
   digit_entry_reg #(.WIDTH(8), .DEPTH(6)) dut8 (.clk(clk), .rst(rst), .bus(u8));

   // Apply one command to the 4x4 instance, wait one edge, sample 1 time unit later.
   task automatic cmd4(input logic c, input logic l, input logic p, input logic d,
                       input logic [3:0] dg, input logic [15:0] di);
      u4.clr = c; u4.ld = l; u4.push = p; u4.del = d; u4.digit = dg; u4.din = di;
      @(posedge clk); #1;
      u4.clr = 0; u4.ld = 0; u4.push = 0; u4.del = 0;
   endtask

   task automatic cmd8(input logic p, input logic [7:0] dg);
      u8.push = p; u8.digit = dg;
      @(posedge clk); #1;
      u8.push = 0;
   endtask

   task automatic test_reset;
      n_tests++; if (u4.dout !== 16'h0) begin n_fail++; $display("FAIL rst_dout got %h exp 0000", u4.dout); end
      n_tests++; if (u4.count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", u4.count); end
      n_tests++; if (u4.empty !== 1'b1 || u4.full !== 1'b0) begin n_fail++; $display("FAIL rst_flags got e=%b f=%b exp e=1 f=0", u4.empty, u4.full); end
      n_tests++; if (u4.ovf !== 1'b0 || u4.unf !== 1'b0) begin n_fail++; $display("FAIL rst_pulses got o=%b u=%b exp 0 0", u4.ovf, u4.unf); end
      cmd4(0, 1, 0, 0, 4'h0, 16'hABCD);
      n_tests++; if (u4.dout !== 16'hABCD) begin n_fail++; $display("FAIL ld_abcd got %h exp abcd", u4.dout); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (u4.dout !== 16'h0 || u4.count !== 3'd0 || u4.empty !== 1'b1) begin
         n_fail++; $display("FAIL async_rst got dout=%h cnt=%0d e=%b exp 0000 0 1", u4.dout, u4.count, u4.empty); end
      #1 rst = 1'b0;
      @(posedge clk); #1;
      cmd4(0, 0, 1, 0, 4'h3, 16'h0);
      cmd4(0, 0, 1, 0, 4'h6, 16'h0);
      n_tests++; if (u4.dout !== 16'h0036 || u4.count !== 3'd2) begin n_fail++; $display("FAIL post_rst_push got %h/%0d exp 0036/2", u4.dout, u4.count); end
      cmd4(1, 0, 0, 0, 4'h0, 16'h0);
      n_tests++; if (u4.dout !== 16'h0 || u4.count !== 3'd0 || u4.empty !== 1'b1) begin
         n_fail++; $display("FAIL clr got dout=%h cnt=%0d e=%b exp 0000 0 1", u4.dout, u4.count, u4.empty); end
   endtask

   task automatic test_push;
      logic [15:0] exp_d [4] = '{16'h0001, 16'h0012, 16'h0123, 16'h1234};
      for (int i = 0; i < 4; i++) begin
         cmd4(0, 0, 1, 0, 4'(i + 1), 16'h0);
         n_tests++; if (u4.dout !== exp_d[i] || u4.count !== 3'(i + 1)) begin
            n_fail++; $display("FAIL push_%0d got %h/%0d exp %h/%0d", i, u4.dout, u4.count, exp_d[i], i + 1); end
      end
      n_tests++; if (u4.full !== 1'b1 || u4.ovf !== 1'b0) begin n_fail++; $display("FAIL push_full got f=%b o=%b exp 1 0", u4.full, u4.ovf); end
      cmd4(0, 0, 1, 0, 4'h5, 16'h0);
      n_tests++; if (u4.dout !== 16'h2345 || u4.count !== 3'd4 || u4.ovf !== 1'b1) begin
         n_fail++; $display("FAIL push_ovf got %h/%0d o=%b exp 2345/4 o=1", u4.dout, u4.count, u4.ovf); end
      cmd4(0, 0, 0, 0, 4'h0, 16'h0);
      n_tests++; if (u4.ovf !== 1'b0 || u4.dout !== 16'h2345) begin n_fail++; $display("FAIL ovf_pulse got o=%b %h exp o=0 2345", u4.ovf, u4.dout); end
   endtask

   task automatic test_delete;
      logic [15:0] exp_d [4] = '{16'h0123, 16'h0012, 16'h0001, 16'h0000};
      cmd4(0, 1, 0, 0, 4'h0, 16'h1234);
      for (int i = 0; i < 4; i++) begin
         cmd4(0, 0, 0, 1, 4'h0, 16'h0);
         n_tests++; if (u4.dout !== exp_d[i] || u4.count !== 3'(3 - i) || u4.unf !== 1'b0) begin
            n_fail++; $display("FAIL del_%0d got %h/%0d u=%b exp %h/%0d u=0", i, u4.dout, u4.count, u4.unf, exp_d[i], 3 - i); end
      end
      n_tests++; if (u4.empty !== 1'b1) begin n_fail++; $display("FAIL del_empty got %b exp 1", u4.empty); end
      cmd4(0, 0, 0, 1, 4'h0, 16'h0);
      n_tests++; if (u4.unf !== 1'b1 || u4.dout !== 16'h0 || u4.count !== 3'd0) begin
         n_fail++; $display("FAIL del_unf got u=%b %h/%0d exp u=1 0000/0", u4.unf, u4.dout, u4.count); end
      cmd4(0, 0, 0, 0, 4'h0, 16'h0);
      n_tests++; if (u4.unf !== 1'b0) begin n_fail++; $display("FAIL unf_pulse got %b exp 0", u4.unf); end
   endtask

   task automatic test_overwrite;
      cmd4(1, 0, 0, 0, 4'h0, 16'h0);
      cmd4(0, 0, 1, 0, 4'h1, 16'h0);
      cmd4(0, 0, 1, 0, 4'h2, 16'h0);
      cmd4(0, 0, 1, 1, 4'h9, 16'h0);
      n_tests++; if (u4.dout !== 16'h0019 || u4.count !== 3'd2 || u4.ovf !== 1'b0 || u4.unf !== 1'b0) begin
         n_fail++; $display("FAIL ovw got %h/%0d o=%b u=%b exp 0019/2 0 0", u4.dout, u4.count, u4.ovf, u4.unf); end
      cmd4(0, 1, 0, 0, 4'h0, 16'h1234);
      cmd4(0, 0, 1, 1, 4'hE, 16'h0);
      n_tests++; if (u4.dout !== 16'h123E || u4.count !== 3'd4 || u4.ovf !== 1'b0) begin
         n_fail++; $display("FAIL ovw_full got %h/%0d o=%b exp 123e/4 0", u4.dout, u4.count, u4.ovf); end
      cmd4(1, 0, 0, 0, 4'h0, 16'h0);
      cmd4(0, 0, 1, 1, 4'h7, 16'h0);
      n_tests++; if (u4.dout !== 16'h0007 || u4.count !== 3'd1 || u4.unf !== 1'b0) begin
         n_fail++; $display("FAIL ovw_empty got %h/%0d u=%b exp 0007/1 0", u4.dout, u4.count, u4.unf); end
   endtask

   task automatic test_priority;
      cmd4(0, 1, 0, 0, 4'h0, 16'h5555);
      cmd4(1, 1, 1, 0, 4'h3, 16'h1234);
      n_tests++; if (u4.dout !== 16'h0 || u4.count !== 3'd0) begin n_fail++; $display("FAIL prio_clr got %h/%0d exp 0000/0", u4.dout, u4.count); end
      cmd4(0, 1, 0, 0, 4'h0, 16'h1111);
      cmd4(0, 1, 1, 0, 4'h3, 16'hBEEF);
      n_tests++; if (u4.dout !== 16'hBEEF || u4.count !== 3'd4 || u4.ovf !== 1'b0) begin
         n_fail++; $display("FAIL prio_ld got %h/%0d o=%b exp beef/4 0", u4.dout, u4.count, u4.ovf); end
      cmd4(1, 0, 0, 0, 4'h0, 16'h0);
      cmd4(0, 1, 0, 1, 4'h0, 16'hCAFE);
      n_tests++; if (u4.dout !== 16'hCAFE || u4.count !== 3'd4 || u4.unf !== 1'b0) begin
         n_fail++; $display("FAIL prio_ld_del got %h/%0d u=%b exp cafe/4 0", u4.dout, u4.count, u4.unf); end
   endtask

   task automatic test_back_to_back;
      cmd4(1, 0, 0, 0, 4'h0, 16'h0);
      cmd4(0, 0, 1, 0, 4'hA, 16'h0);
      n_tests++; if (u4.dout !== 16'h000A || u4.count !== 3'd1) begin n_fail++; $display("FAIL b2b_0 got %h/%0d exp 000a/1", u4.dout, u4.count); end
      cmd4(0, 0, 1, 0, 4'hB, 16'h0);
      n_tests++; if (u4.dout !== 16'h00AB || u4.count !== 3'd2) begin n_fail++; $display("FAIL b2b_1 got %h/%0d exp 00ab/2", u4.dout, u4.count); end
      cmd4(0, 0, 0, 1, 4'h0, 16'h0);
      n_tests++; if (u4.dout !== 16'h000A || u4.count !== 3'd1) begin n_fail++; $display("FAIL b2b_2 got %h/%0d exp 000a/1", u4.dout, u4.count); end
      cmd4(0, 0, 1, 0, 4'hC, 16'h0);
      n_tests++; if (u4.dout !== 16'h00AC || u4.count !== 3'd2 || u4.full !== 1'b0) begin
         n_fail++; $display("FAIL b2b_3 got %h/%0d f=%b exp 00ac/2 0", u4.dout, u4.count, u4.full); end
   endtask

   task automatic test_sweep;
      for (int i = 1; i <= 6; i++) cmd8(1'b1, 8'(i * 17));
      n_tests++; if (u8.dout !== 48'h112233445566 || u8.count !== 3'd6 || u8.full !== 1'b1 || u8.ovf !== 1'b0) begin
         n_fail++; $display("FAIL sweep_full got %h/%0d f=%b o=%b exp 112233445566/6 1 0", u8.dout, u8.count, u8.full, u8.ovf); end
      cmd8(1'b1, 8'h77);
      n_tests++; if (u8.dout !== 48'h223344556677 || u8.count !== 3'd6 || u8.ovf !== 1'b1) begin
         n_fail++; $display("FAIL sweep_ovf got %h/%0d o=%b exp 223344556677/6 1", u8.dout, u8.count, u8.ovf); end
      cmd8(1'b0, 8'h00);
      n_tests++; if (u8.ovf !== 1'b0) begin n_fail++; $display("FAIL sweep_pulse got %b exp 0", u8.ovf); end
   endtask

   initial begin
      u4.clr = 0; u4.ld = 0; u4.push = 0; u4.del = 0; u4.digit = '0; u4.din = '0;
      u8.clr = 0; u8.ld = 0; u8.push = 0; u8.del = 0; u8.digit = '0; u8.din = '0;
      #12 rst = 1'b0;
      @(posedge clk); #1;
      test_reset;
      test_push;
      test_delete;
      test_overwrite;
      test_priority;
      test_back_to_back;
      test_sweep;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
